// File: rtl/fetch_bp_queue_pkg.sv
// Shared widths and the fetch entry record for the fetch/branch-prediction queue.
package fetch_bp_queue_pkg;

  localparam int DEF_BPW = 2;
  localparam int DEF_AW  = 32;

  typedef struct packed {
    logic [DEF_BPW-1:0] bp;
    logic [DEF_AW-1:0]  addr;
    logic [DEF_AW-1:0]  btb;
  } fetch_entry_t;

  function automatic int entry_width(input int bpw, input int aw);
    return bpw + 2 * aw;
  endfunction

endpackage

// File: rtl/fetch_bp_queue_core.sv
// Generic FIFO core: pointer/count bookkeeping plus an unreset storage array.
//   Handshake: a write happens when wr_valid && wr_ready at a rising edge; a read
//   happens when rd_valid && rd_ready. wr_ready depends only on count, never on rd_ready.
module mb_fifo_core #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [W-1:0]             wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign wr_ready = (count != FULL_CNT);
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  // Storage is never reset, so mask it whenever the queue is empty.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_bp_queue.sv
// Fetch/branch-prediction queue: packs the three entry fields into one FIFO word.
module fetch_bp_queue
  import fetch_bp_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DEF_AW,
  parameter int BPW   = DEF_BPW
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Flush,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [BPW-1:0]         FetchBP,
  input  logic [AW-1:0]          FetchAddress,
  input  logic [AW-1:0]          FetchBTBInstruction,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [BPW-1:0]         bFetchBP,
  output logic [AW-1:0]          bFetchAddress,
  output logic [AW-1:0]          bFetchBTBInstruction,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int EW = entry_width(BPW, AW);

  logic [EW-1:0] wr_word;
  logic [EW-1:0] rd_word;

  assign wr_word = {FetchBP, FetchAddress, FetchBTBInstruction};
  assign {bFetchBP, bFetchAddress, bFetchBTBInstruction} = rd_word;

  mb_fifo_core #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_core (
    .clk      (Clk),
    .rst_n    (Rst),
    .flush    (Flush),
    .wr_valid (InValid),
    .wr_ready (InReady),
    .wr_data  (wr_word),
    .rd_valid (OutValid),
    .rd_ready (OutReady),
    .rd_data  (rd_word),
    .count    (Count)
  );

endmodule

// File: tb/tb_fetch_bp_queue.sv
// Self-checking bench for fetch_bp_queue: queue-based reference model plus negedge monitor.
module tb_fetch_bp_queue;
  import fetch_bp_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = entry_width(DEF_BPW, DEF_AW);

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              Flush = 1'b0;
  logic              InValid = 1'b0;
  logic              OutReady = 1'b0;
  logic [DEF_BPW-1:0] FetchBP = '0;
  logic [DEF_AW-1:0]  FetchAddress = '0;
  logic [DEF_AW-1:0]  FetchBTBInstruction = '0;
  logic              InReady;
  logic              OutValid;
  logic [DEF_BPW-1:0] bFetchBP;
  logic [DEF_AW-1:0]  bFetchAddress;
  logic [DEF_AW-1:0]  bFetchBTBInstruction;
  logic [CW-1:0]     Count;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  always #5 Clk = ~Clk;

  fetch_bp_queue #(.DEPTH(DEPTH), .AW(DEF_AW), .BPW(DEF_BPW)) dut (
    .Clk                  (Clk),
    .Rst                  (Rst),
    .Flush                (Flush),
    .InValid              (InValid),
    .InReady              (InReady),
    .FetchBP              (FetchBP),
    .FetchAddress         (FetchAddress),
    .FetchBTBInstruction  (FetchBTBInstruction),
    .OutValid             (OutValid),
    .OutReady             (OutReady),
    .bFetchBP             (bFetchBP),
    .bFetchAddress        (bFetchAddress),
    .bFetchBTBInstruction (bFetchBTBInstruction),
    .Count                (Count)
  );

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries, updated by the handshake rules.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      exp_q.delete();
    end else if (Flush) begin
      exp_q.delete();
    end else begin
      int pre;
      fetch_entry_t e;
      pre = exp_q.size();
      e.bp = FetchBP;
      e.addr = FetchAddress;
      e.btb = FetchBTBInstruction;
      if (OutReady && pre > 0) void'(exp_q.pop_front());
      if (InValid && pre < DEPTH) exp_q.push_back(e);
    end
  end

  // Monitor: compares visible state against the model every cycle.
  always @(negedge Clk) begin
    fetch_entry_t h;
    int n;
    n = exp_q.size();
    check("count", EW'(Count), EW'(n));
    check("out_valid", EW'(OutValid), EW'(n != 0));
    check("in_ready", EW'(InReady), EW'(n != DEPTH));
    if (n > 0) h = exp_q[0];
    else h = '0;
    check("head_bp", EW'(bFetchBP), EW'(h.bp));
    check("head_addr", EW'(bFetchAddress), EW'(h.addr));
    check("head_btb", EW'(bFetchBTBInstruction), EW'(h.btb));
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [DEF_BPW-1:0] bp,
                       input logic [DEF_AW-1:0] a, input logic [DEF_AW-1:0] b);
    InValid = v;
    OutReady = r;
    FetchBP = bp;
    FetchAddress = a;
    FetchBTBInstruction = b;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b1, '0, '0, '0);
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, EW'(Count), '0);
    check({tag, "_out_valid"}, EW'(OutValid), '0);
    check({tag, "_in_ready"}, EW'(InReady), EW'(1));
    check({tag, "_b_fields"}, {bFetchBP, bFetchAddress, bFetchBTBInstruction}, '0);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      InValid = 1'($urandom);
      OutReady = 1'($urandom);
      Flush = 1'($urandom);
      FetchBP = 2'($urandom);
      FetchAddress = $urandom;
      FetchBTBInstruction = $urandom;
      #3;
      check_reset_outputs("reset");
      step();
    end
    Flush = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    #2 Rst = 1'b1;
    step();

    // Single entry into an empty queue
    drive(1'b1, 1'b0, 2'b10, 32'h0040_0010, 32'h0040_0100);
    idle();
    drain();

    // Fill, blocked push when full (also with a simultaneous pop), then wrap
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h100);
    drive(1'b1, 1'b0, 2'b01, 32'h4, 32'h104);
    drive(1'b1, 1'b0, 2'b10, 32'h8, 32'h108);
    drive(1'b1, 1'b0, 2'b11, 32'hC, 32'h10C);
    drive(1'b1, 1'b0, 2'b11, 32'h99, 32'h199);
    drive(1'b1, 1'b1, 2'b11, 32'hAA, 32'h1AA);
    drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 2'b01, 32'h10, 32'h110);
    drive(1'b1, 1'b0, 2'b10, 32'h14, 32'h114);
    drain();

    // Simultaneous push/pop at Count=2
    drive(1'b1, 1'b0, 2'b01, 32'h100, 32'h200);
    drive(1'b1, 1'b0, 2'b10, 32'h104, 32'h204);
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, 2'($urandom), 32'h200 + 32'(i * 4), $urandom);
    drain();

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'($urandom), 32'h300 + 32'(i * 4), $urandom);
    Flush = 1'b1;
    drive(1'b1, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'hFEED_F00D);
    Flush = 1'b0;
    idle();
    idle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'($urandom), 32'h400 + 32'(i * 4), $urandom);
    InValid = 1'b0;
    #3 Rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    #2 Rst = 1'b1;
    step();
    drive(1'b1, 1'b0, 2'b01, 32'h20, 32'h120);
    idle();
    drain();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      Flush = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 9) < 6, 1'($urandom), 2'($urandom), $urandom, $urandom);
    end
    Flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_bp_queue.md
FETCH_BP_QUEUE -- requirements
Module: fetch_bp_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered fetch entries; SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 32, width of address and BTB instruction fields.
REQ-003 Parameter BPW, default 2, width of branch-prediction field.
REQ-004 Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Rst  in  1  reset, asynchronous, active-low.
REQ-006 Flush  in  1  discard all entries (mispredict redirect).
REQ-007 InValid  in  1  producer presents an entry.
REQ-008 InReady  out  1  queue accepts an entry this cycle.
REQ-009 FetchBP  in  BPW  prediction bits of the incoming entry.
REQ-010 FetchAddress  in  AW  fetch PC of the incoming entry.
REQ-011 FetchBTBInstruction  in  AW  BTB target or instruction of the incoming entry.
REQ-012 OutValid  out  1  head entry valid.
REQ-013 OutReady  in  1  consumer takes the head entry this cycle.
REQ-014 bFetchBP  out  BPW  head entry prediction bits.
REQ-015 bFetchAddress  out  AW  head entry fetch PC.
REQ-016 bFetchBTBInstruction  out  AW  head entry BTB field.
REQ-017 Count  out  log2(DEPTH)+1  number of stored entries.

Function
REQ-018 Push occurs when InValid and InReady are both high at a rising edge.
REQ-019 Pop occurs when OutValid and OutReady are both high at a rising edge.
REQ-020 InReady SHALL equal (Count != DEPTH) and SHALL NOT depend combinationally on OutReady.
REQ-021 OutValid SHALL equal (Count != 0).
REQ-022 The b* outputs SHALL present the oldest stored entry; when OutValid is low they SHALL hold zero.
REQ-023 Latency: an entry pushed into an empty queue SHALL appear on the b* outputs with OutValid high on the cycle after the push edge.
REQ-024 Order: entries SHALL be popped in push order with all three fields unchanged.
REQ-025 Push and pop in the same cycle SHALL leave Count unchanged and advance both pointers.
REQ-026 Full (Count = DEPTH): push is blocked by InReady=0, and a pop in the same cycle SHALL NOT admit a push.
REQ-027 Empty: OutReady is ignored; Count SHALL NOT underflow.
REQ-028 Read and write pointers are log2(DEPTH) bits and SHALL wrap modulo DEPTH without a gap.
REQ-029 Flush high at an edge SHALL set Count to 0 and both pointers to 0, dropping any simultaneous push and pop.
REQ-030 Entry contents SHALL NOT be altered except by a push to that slot.

Reset
REQ-031 While Rst is low: Count=0, pointers=0, OutValid=0, InReady=1, all b* outputs zero, regardless of Clk.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately; the first push after release behaves as a push into an empty queue.
REQ-033 Storage array contents need not be reset; they SHALL never be visible while OutValid is low.

Structure
REQ-034 A shared package SHALL hold the default widths (BPW=2, AW=32) and the entry record of prediction, address and BTB fields.
REQ-035 Pointer/count logic and storage SHALL live in one sub-module, mb_fifo_core, parametrised by DEPTH and entry width; fetch_bp_queue packs and unpacks the fields.

Verification
REQ-036 Reset: Rst low with random inputs -> Count=0, OutValid=0, InReady=1, b* = 0.
REQ-037 Single entry: push BP=2'b10, Addr=0x00400010, BTB=0x00400100 into an empty queue, OutReady=0 -> next cycle OutValid=1 and b* equal the pushed values; Count=1.
REQ-038 Fill and wrap: DEPTH=4, push Addr 0x0,0x4,0x8,0xC -> InReady=0 and Count=4; pop two, push 0x10,0x14 -> pop order 0x8,0xC,0x10,0x14.
REQ-039 Simultaneous: Count=2, push and pop every cycle for 10 cycles -> Count stays 2 and the order is preserved.
REQ-040 Flush: Count=3, Flush=1 with InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, and the pushed entry never appears.
REQ-041 Async reset mid-stream: Count=3, drop Rst between edges -> outputs zero before the next edge; after release, push 0x20 -> 0x20 is the head.
